// File: rtl/core_pkg.sv
// Shared pipeline definitions: NOP encoding, fetch FSM states, IF/ID layout.
package core_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // IF/ID register layout: {valid, instr, pcplus4}
  localparam int IF_ID_W = 65;

  typedef enum logic [1:0] {
    FS_ISSUE = 2'd0,
    FS_WAIT  = 2'd1,
    FS_HOLD  = 2'd2,
    FS_DROP  = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with hold (enable low) and synchronous bubble insert.
// KEEP_MASK bits survive a bubble; the rest take CLR_VAL.
module if_id_reg
  import core_pkg::*;
#(
  parameter int           W         = IF_ID_W,
  parameter logic [W-1:0] RST_VAL   = '0,
  parameter logic [W-1:0] CLR_VAL   = '0,
  parameter logic [W-1:0] KEEP_MASK = '0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= RST_VAL;
    end else if (en_i) begin
      if (clr_i) begin
        data_q <= (data_q & KEEP_MASK) | (CLR_VAL & ~KEEP_MASK);
      end else begin
        data_q <= d_i;
      end
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem request FSM and IF/ID register.
// state    | meaning
// ISSUE    | request pc_f, waiting for imem_ready
// WAIT     | request accepted, waiting for rvalid
// HOLD     | word returned under stall, parked in hold buffer
// DROP     | wrong-path request in flight, discard its data
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        branch_taken_d,
  input  logic [31:0] branch_target_d,
  input  logic        jump_d,
  input  logic [31:0] jump_target_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d
);

  localparam logic [IF_ID_W-1:0] IF_ID_RST  = {1'b0, NOP_INSTR, 32'h0000_0000};
  localparam logic [IF_ID_W-1:0] IF_ID_CLR  = {1'b0, NOP_INSTR, 32'h0000_0000};
  localparam logic [IF_ID_W-1:0] IF_ID_KEEP = {1'b0, 32'h0000_0000, 32'hFFFF_FFFF};

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  hold_q;

  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pcplus4;
  logic         load;
  logic [31:0]  load_instr;
  logic [IF_ID_W-1:0] if_id_d;
  logic [IF_ID_W-1:0] if_id_q;

  assign redirect = (jump_d | branch_taken_d) & ~stall_d;
  assign target   = word_align(jump_d ? jump_target_d : branch_target_d);
  assign pcplus4  = pc_q + 32'd4;

  // A returned word reaches IF/ID only if no redirect marks it wrong-path.
  always_comb begin
    load       = 1'b0;
    load_instr = imem_rdata;
    case (state_q)
      FS_WAIT: load = imem_rvalid & ~stall_d & ~redirect;
      FS_HOLD: begin
        load       = ~stall_d & ~redirect;
        load_instr = hold_q;
      end
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FS_ISSUE;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INSTR;
    end else begin
      case (state_q)
        FS_ISSUE: begin
          if (redirect) pc_q <= target;
          if (imem_ready) state_q <= redirect ? FS_DROP : FS_WAIT;
        end
        FS_WAIT: begin
          if (imem_rvalid) begin
            if (redirect) begin
              pc_q    <= target;
              state_q <= FS_ISSUE;
            end else if (stall_d) begin
              hold_q  <= imem_rdata;
              state_q <= FS_HOLD;
            end else begin
              pc_q    <= pcplus4;
              state_q <= FS_ISSUE;
            end
          end else if (redirect) begin
            pc_q    <= target;
            state_q <= FS_DROP;
          end
        end
        FS_HOLD: begin
          if (redirect) begin
            pc_q    <= target;
            state_q <= FS_ISSUE;
          end else if (!stall_d) begin
            pc_q    <= pcplus4;
            state_q <= FS_ISSUE;
          end
        end
        FS_DROP: begin
          if (redirect) pc_q <= target;
          if (imem_rvalid) state_q <= FS_ISSUE;
        end
        default: state_q <= FS_ISSUE;
      endcase
    end
  end

  assign imem_req  = (state_q == FS_ISSUE) & ~reset;
  assign imem_addr = pc_q;

  assign if_id_d = {1'b1, load_instr, pcplus4};

  // pcplus4 is kept across a bubble; only instr and valid are cleared.
  if_id_reg #(
    .W         (IF_ID_W),
    .RST_VAL   (IF_ID_RST),
    .CLR_VAL   (IF_ID_CLR),
    .KEEP_MASK (IF_ID_KEEP)
  ) u_if_id (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (~stall_d),
    .clr_i   (flush_d | ~load),
    .d_i     (if_id_d),
    .q_o     (if_id_q)
  );

  assign valid_d   = if_id_q[64];
  assign instr_d   = if_id_q[63:32];
  assign pcplus4_d = if_id_q[31:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: memory model with credits/latency,
// expected IF/ID loads queued by the stimulus and popped on each real load.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic        branch_taken_d = 1'b0;
  logic [31:0] branch_target_d = 32'h0;
  logic        jump_d = 1'b0;
  logic [31:0] jump_target_d = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;

  // second instance checks PC wrap from the top of the address space
  logic        w_zero = 1'b0;
  logic [31:0] w_zero32 = 32'h0;
  logic        w_ready = 1'b1;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = 32'h0;
  logic [31:0] w_instr;
  logic [31:0] w_pcplus4;
  logic        w_valid;

  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] w_acc[$];
  logic [31:0] w_first_pc4 = 32'hDEAD_BEEF;
  logic        w_seen = 1'b0;
  int          credits = 0;
  int          mem_lat = 1;
  int          m_cnt = 0;
  logic [31:0] m_addr = 32'h0;
  logic        edge_stall;
  logic        edge_reset;

  always #5 clk = ~clk;

  assign imem_ready = (credits > 0);

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall_d         (stall_d),
    .flush_d         (flush_d),
    .branch_taken_d  (branch_taken_d),
    .branch_target_d (branch_target_d),
    .jump_d          (jump_d),
    .jump_target_d   (jump_target_d),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_d         (instr_d),
    .pcplus4_d       (pcplus4_d),
    .valid_d         (valid_d)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk             (clk),
    .reset           (reset),
    .stall_d         (w_zero),
    .flush_d         (w_zero),
    .branch_taken_d  (w_zero),
    .branch_target_d (w_zero32),
    .jump_d          (w_zero),
    .jump_target_d   (w_zero32),
    .imem_req        (w_req),
    .imem_addr       (w_addr),
    .imem_ready      (w_ready),
    .imem_rvalid     (w_rvalid),
    .imem_rdata      (w_rdata),
    .instr_d         (w_instr),
    .pcplus4_d       (w_pcplus4),
    .valid_d         (w_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h8C00_0000 | a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // main imem model: accepts while credits remain, answers after mem_lat cycles
  always @(posedge clk) begin
    if (reset) begin
      m_cnt       <= 0;
      imem_rvalid <= 1'b0;
    end else begin
      imem_rvalid <= 1'b0;
      if (imem_req && imem_ready) begin
        credits <= credits - 1;
        acc_q.push_back(imem_addr);
        if (mem_lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_word(imem_addr);
        end else begin
          m_cnt  <= mem_lat - 1;
          m_addr <= imem_addr;
        end
      end else if (m_cnt == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_word(m_addr);
        m_cnt       <= 0;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // wrap-instance memory: always ready, one-cycle latency
  always @(posedge clk) begin
    if (reset) begin
      w_rvalid <= 1'b0;
    end else begin
      w_rvalid <= w_req;
      w_rdata  <= mem_word(w_addr);
      if (w_req && w_acc.size() < 4) w_acc.push_back(w_addr);
    end
  end

  always @(posedge clk) begin
    edge_stall = stall_d;
    edge_reset = reset;
  end

  // a new IF/ID load is valid_d high after an edge that was neither stalled nor reset
  always @(negedge clk) begin
    if (!edge_reset && !edge_stall && valid_d === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_load", instr_d, 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_instr", instr_d, e.instr);
        chk("sb_pc4", pcplus4_d, e.pc4);
      end
    end
    if (!edge_reset && w_valid === 1'b1 && !w_seen) begin
      w_first_pc4 = w_pcplus4;
      w_seen      = 1'b1;
    end
  end

  task automatic push_exp(input logic [31:0] addr);
    exp_t e;
    e.instr = mem_word(addr);
    e.pc4   = addr + 32'd4;
    sb_q.push_back(e);
  endtask

  task automatic wait_sb(input string tag, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_valid", valid_d, 1'b0);
    chk("rst_instr", instr_d, 32'h0);
    chk("rst_pc4", pcplus4_d, 32'h0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);

    // 1: straight-line fetch
    mem_lat = 1;
    credits = 3;
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    reset = 1'b0;
    wait_sb("t1_drain", 40);
    chk("t1_acc_n", acc_q.size(), 3);
    chk("t1_acc0", acc_q[0], 32'h0);
    chk("t1_acc1", acc_q[1], 32'h4);
    chk("t1_acc2", acc_q[2], 32'h8);
    chk("wrap_seen", w_seen, 1'b1);
    chk("wrap_pc4", w_first_pc4, 32'h0);
    chk("wrap_acc0", w_acc[0], 32'hFFFF_FFFC);
    chk("wrap_acc1", w_acc[1], 32'h0);

    // 2: request not accepted for 3 cycles
    acc_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("t2_req", imem_req, 1'b1);
      chk("t2_addr", imem_addr, 32'hC);
      chk("t2_valid", valid_d, 1'b0);
    end
    credits = 1;
    push_exp(32'hC);
    wait_sb("t2_drain", 20);
    chk("t2_acc", acc_q[0], 32'hC);

    // 3: stall holds IF/ID while data returns into the hold buffer
    acc_q.delete();
    stall_d = 1'b1;
    mem_lat = 1;
    credits = 1;
    tick();
    chk("t3_hold_instr0", instr_d, mem_word(32'hC));
    chk("t3_hold_valid0", valid_d, 1'b1);
    tick();
    chk("t3_hold_instr1", instr_d, mem_word(32'hC));
    tick();
    chk("t3_hold_instr2", instr_d, mem_word(32'hC));
    chk("t3_hold_pc4", pcplus4_d, 32'h10);
    stall_d = 1'b0;
    push_exp(32'h10);
    wait_sb("t3_drain", 20);
    credits = 1;
    push_exp(32'h14);
    wait_sb("t3_next", 20);
    chk("t3_acc_n", acc_q.size(), 2);
    chk("t3_acc1", acc_q[1], 32'h14);

    // 4: branch while request 0x18 is in flight -> DROP
    acc_q.delete();
    mem_lat = 4;
    credits = 1;
    tick();
    branch_taken_d  = 1'b1;
    branch_target_d = 32'h42;
    mem_lat = 1;
    credits = 1;
    push_exp(32'h40);
    tick();
    branch_taken_d = 1'b0;
    chk("t4_req_drop", imem_req, 1'b0);
    chk("t4_addr", imem_addr, 32'h40);
    repeat (3) begin
      @(negedge clk);
      chk("t4_bubble", valid_d, 1'b0);
    end
    wait_sb("t4_drain", 20);
    chk("t4_acc_n", acc_q.size(), 2);
    chk("t4_acc1", acc_q[1], 32'h40);

    // 5: jump beats branch; stalled redirect ignored
    acc_q.delete();
    jump_d          = 1'b1;
    jump_target_d   = 32'h100;
    branch_taken_d  = 1'b1;
    branch_target_d = 32'h80;
    tick();
    jump_d         = 1'b0;
    branch_taken_d = 1'b0;
    chk("t5_addr", imem_addr, 32'h100);
    credits = 1;
    push_exp(32'h100);
    wait_sb("t5_drain", 20);
    chk("t5_acc", acc_q[0], 32'h100);
    stall_d         = 1'b1;
    jump_d          = 1'b1;
    jump_target_d   = 32'h200;
    branch_taken_d  = 1'b1;
    branch_target_d = 32'h80;
    tick();
    jump_d         = 1'b0;
    branch_taken_d = 1'b0;
    chk("t5_stall_addr", imem_addr, 32'h104);
    chk("t5_stall_valid", valid_d, 1'b1);
    stall_d = 1'b0;
    credits = 1;
    push_exp(32'h104);
    wait_sb("t5_next", 20);

    // flush: masked by stall, otherwise bubble with pcplus4 kept
    stall_d = 1'b1;
    flush_d = 1'b1;
    tick();
    chk("fl_stall_valid", valid_d, 1'b1);
    chk("fl_stall_instr", instr_d, mem_word(32'h104));
    stall_d = 1'b0;
    tick();
    flush_d = 1'b0;
    chk("fl_valid", valid_d, 1'b0);
    chk("fl_instr", instr_d, 32'h0);
    chk("fl_pc4", pcplus4_d, 32'h108);

    // 6: reset while waiting for data
    credits = 1;
    push_exp(32'h108);
    wait_sb("t6_pre", 20);
    stall_d = 1'b1;
    mem_lat = 5;
    credits = 1;
    tick();
    chk("t6_wait_valid", valid_d, 1'b1);
    chk("t6_wait_req", imem_req, 1'b0);
    reset = 1'b1;
    tick();
    chk("t6_rst_valid", valid_d, 1'b0);
    chk("t6_rst_instr", instr_d, 32'h0);
    chk("t6_rst_pc4", pcplus4_d, 32'h0);
    chk("t6_rst_addr", imem_addr, 32'h0);
    acc_q.delete();
    reset   = 1'b0;
    stall_d = 1'b0;
    mem_lat = 1;
    credits = 1;
    push_exp(32'h0);
    wait_sb("t6_restart", 20);
    chk("t6_acc", acc_q[0], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core. Sits directly upstream of decode.
- Holds the PC and issues one word request at a time to instruction memory over a req/ready + rvalid handshake.
- Drives the IF/ID pipeline register, whose instr_d[31:26] feeds the main decoder opcode.
- Applies stall, flush and branch/jump redirects from the decode-stage hazard logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- stall_d  input  1  hold the IF/ID register and the PC.
- flush_d  input  1  replace the IF/ID contents with a bubble.
- branch_taken_d  input  1  taken-branch redirect.
- branch_target_d  input  32  branch target.
- jump_d  input  1  jump redirect.
- jump_target_d  input  32  jump target.
- imem_req  output  1  request valid.
- imem_addr  output  32  word address (byte-addressed, [1:0]=00).
- imem_ready  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  instruction word.
- instr_d  output  32  IF/ID instruction.
- pcplus4_d  output  32  IF/ID PC+4.
- valid_d  output  1  instr_d holds a real instruction.

Behaviour:
- Reset values: pc_f=RESET_PC, state=ISSUE, imem_req=0 during the reset cycle, instr_d=32'h0 (NOP), pcplus4_d=0, valid_d=0, hold buffer empty.
- Only one request may be outstanding. Data return latency is at least 1 cycle after acceptance and is unbounded.
- Redirect definition: redirect = (jump_d | branch_taken_d) & ~stall_d.
  - jump_d has priority over branch_taken_d.
  - target[1:0] is forced to 00.
  - stall_d masks redirect and flush_d.
- ISSUE state:
  - imem_req=1, imem_addr=pc_f.
  - Redirect without imem_ready: pc_f=target, stay in ISSUE. The address may change because the request was not accepted.
  - imem_ready without redirect: go to WAIT.
  - imem_ready with redirect: pc_f=target, go to DROP.
- WAIT state (imem_req=0):
  - rvalid & ~stall_d & ~redirect: load IF/ID with instr_d=rdata, pcplus4_d=pc_f+4, valid_d=1. Then pc_f+=4, go to ISSUE.
  - rvalid & stall_d: capture rdata in the hold buffer, go to HOLD.
  - redirect & rvalid: drop the data, pc_f=target, go to ISSUE.
  - redirect & ~rvalid: pc_f=target, go to DROP.
- HOLD state:
  - ~stall_d & ~redirect: load IF/ID from the buffer, pc_f+=4, go to ISSUE.
  - redirect: discard the buffer, pc_f=target, go to ISSUE.
- DROP state: wait for rvalid, discard the data, go to ISSUE. A new redirect while in DROP updates pc_f.
- IF/ID update priority, highest first:
  1. stall_d: hold all of instr_d, pcplus4_d, valid_d.
  2. flush_d: bubble, instr_d=0 and valid_d=0. pcplus4_d is don't-care and is held.
  3. New word available: load it.
  4. Otherwise: bubble.
- Load and redirect in the same cycle: the redirect wins and the word is dropped. The fetched word is sequential and lies on the wrong path.
- pc_f+4 wraps modulo 2^32: 0xFFFF_FFFC becomes 0x0000_0000.
- Reset asserted mid-operation: all state returns to reset values next edge. imem shares this reset, so no stale rvalid is required to be handled.

Decomposition:
- Shared package (core_pkg): NOP_INSTR=32'h0, fetch state encoding ISSUE/WAIT/HOLD/DROP, default RESET_PC.
- One sub-module: if_id_reg, a 65-bit register with enable (~stall_d) and synchronous clear (bubble). Reused later for the ID/EX register pattern.

Test Plan:
1. Reset, then imem_ready=1 and rvalid 1 cycle after accept, no stalls -> imem_addr 0x0, 0x4, 0x8; valid_d=0 through reset; instr_d follows rdata; pcplus4_d=0x4, 0x8, 0xC.
2. imem_ready held low 3 cycles -> imem_req=1 and imem_addr=0x4 stable throughout; no IF/ID load until rvalid.
3. stall_d=1 for 2 cycles with rvalid arriving in stall cycle 1 -> instr_d unchanged; on release the buffered word appears with pcplus4_d=prev+4; next imem_addr advances by exactly 4.
4. branch_taken_d=1, target 0x40, with a request for 0x8 outstanding (DROP path) -> response for 0x8 discarded; next imem_addr=0x40; valid_d=0 for the bubble cycles; then instr from 0x40 with pcplus4_d=0x44.
5. jump_d=1 (target 0x100) and branch_taken_d=1 (target 0x80) in the same cycle, stall_d=0 -> next accepted address 0x100. Repeat with stall_d=1 -> redirect ignored, pc_f unchanged.
6. RESET_PC=32'hFFFF_FFFC -> first pcplus4_d=0x0 and second imem_addr=0x0 (wrap). Assert reset while in WAIT -> next cycle valid_d=0, instr_d=0, fetch restarts at RESET_PC.
